// File: rtl/diff_drive_odometry_if.sv
// Sample channel from the odometry block to the navigation controller.
// Handshake: the producer raises sample_valid with the four result words and
// holds valid and data stable until the consumer samples sample_ready high on
// a clock edge while valid is high. That edge is the transfer. Valid never
// drops without a transfer, except on reset or clear.
interface diff_drive_odometry_if #(
    parameter int CNT_W = 32
);
    logic                    sample_valid;
    logic                    sample_ready;
    logic signed [CNT_W-1:0] dist_left;
    logic signed [CNT_W-1:0] dist_right;
    logic signed [CNT_W-1:0] average_distance;
    logic signed [CNT_W-1:0] delta_theta;

    modport master (
        output sample_valid,
        output dist_left,
        output dist_right,
        output average_distance,
        output delta_theta,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  dist_left,
        input  dist_right,
        input  average_distance,
        input  delta_theta,
        output sample_ready
    );
endinterface

// File: rtl/diff_drive_odometry.sv
// Differential-drive odometry: two 4x quadrature decoders, free-running tick
// positions, per-window tick accumulation and a per-window result
// (distances, average, heading change) offered on a valid/ready channel.
// Optional feature macro: ODO_HEADING_ACC_EN adds a wrapped heading accumulator
// (mrad, kept in [-3141,3141]) updated on every accepted sample.
module diff_drive_odometry #(
    parameter int CNT_W          = 32,
    parameter int DIST_PER_PULSE = 628,
    parameter int K_THETA_Q16    = 65536,
    parameter int SAMPLE_CYCLES  = 50000,
    parameter bit RIGHT_INVERT   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    A_left,
    input  logic                    B_left,
    input  logic                    A_right,
    input  logic                    B_right,
    input  logic                    clear,
    diff_drive_odometry_if.master   smp,
    output logic signed [CNT_W-1:0] pos_left,
    output logic signed [CNT_W-1:0] pos_right,
    output logic [1:0]              enc_error,
    output logic                    sample_overrun,
    output logic [1:0]              fsm_state_dbg
`ifdef ODO_HEADING_ACC_EN
    ,
    output logic signed [CNT_W-1:0] heading
`endif
);

    localparam int PW    = 2 * CNT_W;
    localparam int TMR_W = $clog2(SAMPLE_CYCLES);
    localparam logic [TMR_W-1:0]        TMR_LAST  = TMR_W'(SAMPLE_CYCLES - 1);
    localparam logic signed [PW-1:0]    DPP_X     = PW'(DIST_PER_PULSE);
    localparam logic signed [PW-1:0]    K_X       = PW'(K_THETA_Q16);
    localparam logic signed [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic signed [CNT_W-1:0] MINUS_ONE = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0] sync1_l_q, sync2_l_q, prev_l_q;
    logic [1:0] sync1_r_q, sync2_r_q, prev_r_q;

    logic [TMR_W-1:0]        timer_q;
    logic signed [CNT_W-1:0] pos_l_q, pos_r_q;
    logic signed [CNT_W-1:0] acc_l_q, acc_r_q;
    logic signed [CNT_W-1:0] snap_l_q, snap_r_q;
    logic signed [CNT_W-1:0] dl_q, dr_q, avg_q, dth_q;
    logic                    valid_q;
    logic [1:0]              err_q;
    logic                    ovr_q;

    logic [1:0]              step_l, step_r;
    logic signed [CNT_W-1:0] tick_l, tick_r;
    logic                    ill_l, ill_r;
    logic                    window_end;
    logic                    snap_en, calc_en, accept, overrun_set;

    logic signed [PW-1:0]    prod_l, prod_r, sum_x, diff_x, theta_x;
    logic signed [CNT_W-1:0] dl_c, dr_c, avg_c, dth_c;

    // Position of a Gray-coded phase along the forward sequence 00,01,11,10.
    function automatic logic [1:0] phase(input logic [1:0] ab);
        case (ab)
            2'b00:   phase = 2'd0;
            2'b01:   phase = 2'd1;
            2'b11:   phase = 2'd2;
            default: phase = 2'd3;
        endcase
    endfunction

    function automatic logic signed [PW-1:0] sx(input logic signed [CNT_W-1:0] v);
        sx = {{CNT_W{v[CNT_W-1]}}, v};
    endfunction

    // Two-flop synchronisers plus the previous-phase register of each encoder.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_l_q <= '0;
            sync2_l_q <= '0;
            prev_l_q  <= '0;
            sync1_r_q <= '0;
            sync2_r_q <= '0;
            prev_r_q  <= '0;
        end else begin
            sync1_l_q <= {A_left, B_left};
            sync2_l_q <= sync1_l_q;
            prev_l_q  <= sync2_l_q;
            sync1_r_q <= {A_right, B_right};
            sync2_r_q <= sync1_r_q;
            prev_r_q  <= sync2_r_q;
        end
    end

    // Phase difference decodes to +1, -1, none, or illegal (both bits moved).
    always_comb begin
        step_l = phase(sync2_l_q) - phase(prev_l_q);
        step_r = phase(sync2_r_q) - phase(prev_r_q);
        tick_l = '0;
        tick_r = '0;
        ill_l  = 1'b0;
        ill_r  = 1'b0;
        case (step_l)
            2'd1:    tick_l = ONE;
            2'd3:    tick_l = MINUS_ONE;
            2'd2:    ill_l  = 1'b1;
            default: tick_l = '0;
        endcase
        // The right encoder is mounted mirrored, so its sense may be flipped.
        case (step_r)
            2'd1:    tick_r = RIGHT_INVERT ? MINUS_ONE : ONE;
            2'd3:    tick_r = RIGHT_INVERT ? ONE : MINUS_ONE;
            2'd2:    ill_r  = 1'b1;
            default: tick_r = '0;
        endcase
    end

    assign window_end = (timer_q == TMR_LAST);

    // Window arithmetic on the snapshot; products are full width, then truncated.
    always_comb begin
        prod_l  = sx(snap_l_q) * DPP_X;
        prod_r  = sx(snap_r_q) * DPP_X;
        dl_c    = prod_l[CNT_W-1:0];
        dr_c    = prod_r[CNT_W-1:0];
        sum_x   = sx(dl_c) + sx(dr_c);
        avg_c   = sum_x[CNT_W:1];
        diff_x  = sx(dr_c) - sx(dl_c);
        theta_x = diff_x * K_X;
        dth_c   = theta_x[CNT_W+15:16];
    end

    // FSM state register; clear aborts any sample in flight.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and the strobes that steer the datapath.
    always_comb begin
        state_d     = state_q;
        snap_en     = 1'b0;
        calc_en     = 1'b0;
        accept      = 1'b0;
        overrun_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (window_end) begin
                    snap_en = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                calc_en = 1'b1;
                state_d = ST_VALID;
            end
            ST_VALID: begin
                if (valid_q && smp.sample_ready) begin
                    accept  = 1'b1;
                    state_d = ST_IDLE;
                end
                // A window closing while a sample is still owed is skipped;
                // its ticks stay in the accumulator for the next snapshot.
                if (window_end) begin
                    overrun_set = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer, positions, accumulators, snapshot, results and sticky flags.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            timer_q  <= '0;
            pos_l_q  <= '0;
            pos_r_q  <= '0;
            acc_l_q  <= '0;
            acc_r_q  <= '0;
            snap_l_q <= '0;
            snap_r_q <= '0;
            dl_q     <= '0;
            dr_q     <= '0;
            avg_q    <= '0;
            dth_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= '0;
            ovr_q    <= 1'b0;
        end else begin
            timer_q <= window_end ? '0 : timer_q + 1'b1;
            pos_l_q <= pos_l_q + tick_l;
            pos_r_q <= pos_r_q + tick_r;
            err_q   <= err_q | {ill_r, ill_l};
            // A tick landing on the window-end cycle opens the new window.
            if (snap_en) begin
                snap_l_q <= acc_l_q;
                snap_r_q <= acc_r_q;
                acc_l_q  <= tick_l;
                acc_r_q  <= tick_r;
            end else begin
                acc_l_q <= acc_l_q + tick_l;
                acc_r_q <= acc_r_q + tick_r;
            end
            if (calc_en) begin
                dl_q    <= dl_c;
                dr_q    <= dr_c;
                avg_q   <= avg_c;
                dth_q   <= dth_c;
                valid_q <= 1'b1;
            end else if (accept) begin
                valid_q <= 1'b0;
            end
            if (overrun_set) begin
                ovr_q <= 1'b1;
            end
        end
    end

`ifdef ODO_HEADING_ACC_EN
    localparam int HW = CNT_W + 1;
    localparam logic signed [HW-1:0] H_MAX  = HW'(3141);
    localparam logic signed [HW-1:0] H_MIN  = HW'(-3141);
    localparam logic signed [HW-1:0] H_SPAN = HW'(6283);

    logic signed [CNT_W-1:0] heading_q, heading_d;
    logic signed [HW-1:0]    h_sum, h_wrap;

    // Heading plus this sample's change, folded back once into +/- pi mrad.
    always_comb begin
        h_sum  = {heading_q[CNT_W-1], heading_q} + {dth_q[CNT_W-1], dth_q};
        h_wrap = h_sum;
        if (h_sum > H_MAX) begin
            h_wrap = h_sum - H_SPAN;
        end else if (h_sum < H_MIN) begin
            h_wrap = h_sum + H_SPAN;
        end
        heading_d = h_wrap[CNT_W-1:0];
    end

    // Heading advances only when the consumer takes a sample.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            heading_q <= '0;
        end else if (accept) begin
            heading_q <= heading_d;
        end
    end

    assign heading = heading_q;
`endif

    assign smp.sample_valid     = valid_q;
    assign smp.dist_left        = dl_q;
    assign smp.dist_right       = dr_q;
    assign smp.average_distance = avg_q;
    assign smp.delta_theta      = dth_q;
    assign pos_left             = pos_l_q;
    assign pos_right            = pos_r_q;
    assign enc_error            = err_q;
    assign sample_overrun       = ovr_q;
    assign fsm_state_dbg        = state_q;

endmodule
